uart_sram_tx_interface: RTL and testbench



---
 rtl/uart_sram_tx_interface.sv | 154 +++++++++++++++
 tb/tb_uart_sram_tx_interface.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_sram_tx_interface.sv
// Streams a block of 16-bit SRAM words out of a UART TX pin, high byte first.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit (8E1 instead of 8N1 frames).
module uart_sram_tx_interface #(
  parameter int CLOCKS_PER_BIT    = 434,
  parameter int SRAM_READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic        Abort,
  input  logic [17:0] Base_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int SHIFT_W = FRAME_BITS - 1;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int LAT_W   = (SRAM_READ_LATENCY > 1) ? $clog2(SRAM_READ_LATENCY) : 1;

  typedef enum logic [3:0] {
    S_TX_IDLE, S_TX_ISSUE_READ, S_TX_WAIT_READ, S_TX_LOAD_HI, S_TX_SEND_HI,
    S_TX_LOAD_LO, S_TX_SEND_LO, S_TX_NEXT, S_TX_DONE
  } tx_state_e;

  tx_state_e          state_reg, state_next;
  logic [17:0]        addr_reg, sram_addr_reg, remaining_reg;
  logic [15:0]        word_reg;
  logic [SHIFT_W-1:0] shift_reg;
  logic [CNT_W-1:0]   bit_cnt_reg;
  logic [IDX_W-1:0]   bit_idx_reg;
  logic [LAT_W-1:0]   lat_cnt_reg;
  logic               tx_reg, busy_reg, done_reg, abort_seen_reg;

  logic bit_wrap, frame_end, lat_done;
  logic accept, capture, load_frame, sending, advance, finish;
  logic [7:0]         load_byte;
  logic [SHIFT_W-1:0] frame_payload;

  assign bit_wrap  = (bit_cnt_reg == CNT_W'(CLOCKS_PER_BIT - 1));
  assign frame_end = bit_wrap && (bit_idx_reg == IDX_W'(FRAME_BITS - 1));
  assign lat_done  = (lat_cnt_reg == LAT_W'(SRAM_READ_LATENCY - 1));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_reg <= S_TX_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_TX_IDLE:       if (Start) state_next = (Word_count == 18'd0) ? S_TX_DONE : S_TX_ISSUE_READ;
      S_TX_ISSUE_READ: state_next = S_TX_WAIT_READ;
      S_TX_WAIT_READ:  if (lat_done) state_next = S_TX_LOAD_HI;
      S_TX_LOAD_HI:    state_next = S_TX_SEND_HI;
      S_TX_SEND_HI:    if (frame_end) state_next = Abort ? S_TX_DONE : S_TX_LOAD_LO;
      S_TX_LOAD_LO:    state_next = S_TX_SEND_LO;
      S_TX_SEND_LO:    if (frame_end) state_next = S_TX_NEXT;
      S_TX_NEXT:       state_next = (remaining_reg == 18'd1 || abort_seen_reg) ? S_TX_DONE : S_TX_ISSUE_READ;
      S_TX_DONE:       state_next = S_TX_IDLE;
      default:         state_next = S_TX_IDLE;
    endcase
  end

  always_comb begin
    accept     = (state_reg == S_TX_IDLE) && Start;
    capture    = (state_reg == S_TX_WAIT_READ) && lat_done;
    load_frame = (state_reg == S_TX_LOAD_HI) || (state_reg == S_TX_LOAD_LO);
    sending    = (state_reg == S_TX_SEND_HI) || (state_reg == S_TX_SEND_LO);
    advance    = (state_reg == S_TX_NEXT);
    finish     = (state_reg == S_TX_DONE);
    load_byte  = (state_reg == S_TX_LOAD_HI) ? word_reg[15:8] : word_reg[7:0];
`ifdef UART_TX_PARITY_EN
    frame_payload = {1'b1, ^load_byte, load_byte};
`else
    frame_payload = {1'b1, load_byte};
`endif
  end

  // The start bit is driven from the load cycle's edge, so the line stays high through that cycle.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      addr_reg       <= '0;
      sram_addr_reg  <= '0;
      remaining_reg  <= '0;
      word_reg       <= '0;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      bit_idx_reg    <= '0;
      lat_cnt_reg    <= '0;
      tx_reg         <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      abort_seen_reg <= 1'b0;
    end else begin
      done_reg <= finish;
      if (accept) begin
        addr_reg       <= Base_address;
        remaining_reg  <= Word_count;
        busy_reg       <= (Word_count != 18'd0);
        abort_seen_reg <= 1'b0;
      end else if (finish) begin
        busy_reg <= 1'b0;
      end
      if (state_reg == S_TX_ISSUE_READ) begin
        sram_addr_reg <= addr_reg;
        lat_cnt_reg   <= '0;
      end
      if (state_reg == S_TX_WAIT_READ) lat_cnt_reg <= lat_cnt_reg + 1'b1;
      if (capture) word_reg <= SRAM_read_data;
      if (load_frame) begin
        shift_reg   <= frame_payload;
        tx_reg      <= 1'b0;
        bit_cnt_reg <= '0;
        bit_idx_reg <= '0;
      end
      if (sending) begin
        if (bit_wrap) begin
          bit_cnt_reg <= '0;
          if (!frame_end) begin
            tx_reg      <= shift_reg[0];
            shift_reg   <= {1'b1, shift_reg[SHIFT_W-1:1]};
            bit_idx_reg <= bit_idx_reg + 1'b1;
          end else if (state_reg == S_TX_SEND_LO) begin
            abort_seen_reg <= Abort;
          end
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end
      if (advance) begin
        remaining_reg <= remaining_reg - 18'd1;
        addr_reg      <= addr_reg + 18'd1;
      end
    end
  end

  assign SRAM_address = sram_addr_reg;
  assign SRAM_we_n    = 1'b1;
  assign UART_TX_O    = tx_reg;
  assign Busy         = busy_reg;
  assign Done         = done_reg;

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Directed bench for uart_sram_tx_interface with a fast bit rate and a small SRAM image.
// Honours UART_TX_PARITY_EN when the same macro is defined for the bench build.
module tb_uart_sram_tx_interface;
  localparam int CPB = 4;
  localparam int LAT = 2;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int NS = FB * CPB;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [17:0] Base_address = '0;
  logic [17:0] Word_count = '0;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        UART_TX_O, Busy, Done;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int we_bad    = 0;

  always #5 Clock = ~Clock;

  always_comb begin
    case (SRAM_address)
      18'h00000: SRAM_read_data = 16'hA55A;
      18'h3FFFF: SRAM_read_data = 16'h1234;
      18'h00100: SRAM_read_data = 16'hC3C3;
      18'h00200: SRAM_read_data = 16'hF00F;
      18'h00300: SRAM_read_data = 16'h0301;
      default:   SRAM_read_data = 16'hDEAD;
    endcase
  end

  always @(negedge Clock) if (SRAM_we_n !== 1'b1) we_bad++;

  uart_sram_tx_interface #(.CLOCKS_PER_BIT(CPB), .SRAM_READ_LATENCY(LAT)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Abort(Abort),
    .Base_address(Base_address), .Word_count(Word_count),
    .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data),
    .UART_TX_O(UART_TX_O), .Busy(Busy), .Done(Done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [FB-1:0] frame_bits(input logic [7:0] b);
    logic [FB-1:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  task automatic start_xfer(input logic [17:0] base, input logic [17:0] cnt);
    @(negedge Clock);
    Base_address = base;
    Word_count   = cnt;
    Start        = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Waits for a start bit, then captures every cycle of the frame; gap = idle cycles seen first.
  task automatic get_frame(input string tag, input logic [7:0] b, input int abort_at, output int gap);
    logic [NS-1:0] got, exp;
    logic [FB-1:0] f;
    gap = 0;
    while (UART_TX_O !== 1'b0 && gap < 2000) begin
      @(negedge Clock);
      gap++;
    end
    f = frame_bits(b);
    for (int i = 0; i < NS; i++) begin
      if (i == abort_at) Abort = 1'b1;
      got[i] = UART_TX_O;
      exp[i] = f[i / CPB];
      @(negedge Clock);
    end
    $display("frame %s: byte %02h gap %0d line %0h", tag, b, gap, got);
    check(tag, got, exp);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (Done !== 1'b1 && n < 200) begin
      @(negedge Clock);
      n++;
    end
  endtask

  task automatic count_lows(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clock);
      if (UART_TX_O !== 1'b1) lows++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, n, lows;
    repeat (3) @(negedge Clock);
    check("rst_tx", UART_TX_O, 1'b1);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_addr", SRAM_address, 18'h0);
    check("rst_we", SRAM_we_n, 1'b1);
    Resetn = 1'b1;
    @(negedge Clock);

    // One word, two back-to-back frames separated by a single load cycle
    start_xfer(18'h0, 18'd1);
    check("basic_busy", Busy, 1'b1);
    get_frame("basic_hi", 8'hA5, -1, gap);
    get_frame("basic_lo", 8'h5A, -1, gap);
    check("basic_gap", gap, 1);
    wait_done(n);
    $display("done basic after %0d cycles", n);
    check("basic_done_lat", n, 2);
    check("basic_busy_end", Busy, 1'b0);
    @(negedge Clock);
    check("basic_done_pulse", Done, 1'b0);

    // Empty transfer: Done two cycles after Start, no line or address activity
    start_xfer(18'h155, 18'd0);
    check("zero_done_early", Done, 1'b0);
    check("zero_busy1", Busy, 1'b0);
    @(negedge Clock);
    $display("zero count: done %b busy %b tx %b addr %05h", Done, Busy, UART_TX_O, SRAM_address);
    check("zero_done", Done, 1'b1);
    check("zero_busy2", Busy, 1'b0);
    check("zero_tx", UART_TX_O, 1'b1);
    check("zero_addr", SRAM_address, 18'h0);
    @(negedge Clock);
    check("zero_done_pulse", Done, 1'b0);

    // Address wrap from the top of SRAM
    start_xfer(18'h3FFFF, 18'd2);
    get_frame("wrap_hi0", 8'h12, -1, gap);
    check("wrap_addr0", SRAM_address, 18'h3FFFF);
    get_frame("wrap_lo0", 8'h34, -1, gap);
    get_frame("wrap_hi1", 8'hA5, -1, gap);
    check("wrap_addr1", SRAM_address, 18'h00000);
    get_frame("wrap_lo1", 8'h5A, -1, gap);
    wait_done(n);
    check("wrap_done_lat", n, 2);
    check("wrap_we", we_bad, 0);

    // Abort raised mid high-byte frame: frame completes, low byte skipped
    start_xfer(18'h100, 18'd3);
    get_frame("abort_hi", 8'hC3, 20, gap);
    wait_done(n);
    $display("abort done after %0d cycles", n);
    check("abort_done_lat", n, 1);
    count_lows(60, lows);
    check("abort_no_more_frames", lows, 0);
    check("abort_busy", Busy, 1'b0);
    Abort = 1'b0;

    // Reset during data bit 3 of the 0xF0 frame
    start_xfer(18'h200, 18'd1);
    n = 0;
    while (UART_TX_O !== 1'b0 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    repeat (16) @(negedge Clock);
    check("midrst_bit3_low", UART_TX_O, 1'b0);
    #1 Resetn = 1'b0;
    #1;
    $display("reset mid-frame: tx %b busy %b", UART_TX_O, Busy);
    check("midrst_tx", UART_TX_O, 1'b1);
    check("midrst_busy", Busy, 1'b0);
    @(negedge Clock);
    Resetn = 1'b1;
    count_lows(30, lows);
    check("midrst_no_resume", lows, 0);
    start_xfer(18'h200, 18'd1);
    get_frame("midrst_hi", 8'hF0, -1, gap);
    get_frame("midrst_lo", 8'h0F, -1, gap);
    wait_done(n);
    check("midrst_done_lat", n, 2);

    // Parity-sensitive word (0x03 even, 0x01 odd ones count)
    start_xfer(18'h300, 18'd1);
    get_frame("par_hi", 8'h03, -1, gap);
    get_frame("par_lo", 8'h01, -1, gap);
    wait_done(n);
    check("par_done_lat", n, 2);
    check("final_we", we_bad, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
